// File: rtl/wf_issue_rr_arbiter_pkg.sv
// wf_issue_rr_arbiter_pkg: shared defaults and state encoding for the wavefront issue arbiter
package wf_issue_rr_arbiter_pkg;
    localparam int NUM_WF_DEFAULT = 40;
    localparam int WFID_W_DEFAULT = 6;
    localparam int WF_PTR_RESET   = 39;
    typedef enum logic {ARB_IDLE = 1'b0, ARB_GRANT = 1'b1} arb_state_e;
endpackage

// File: rtl/wf_issue_rr_arbiter_pick.sv
// wf_rr_pick: first set request strictly after ptr_i, wrapping at NUM_WF
//   req_i   per-slot request vector
//   ptr_i   last granted slot; search starts at ptr_i+1
//   found_o any request set
//   idx_o   selected slot index
module wf_rr_pick
    import wf_issue_rr_arbiter_pkg::*;
#(
    parameter int NUM_WF = NUM_WF_DEFAULT,
    parameter int WFID_W = WFID_W_DEFAULT
) (
    input  logic [NUM_WF-1:0] req_i,
    input  logic [WFID_W-1:0] ptr_i,
    output logic              found_o,
    output logic [WFID_W-1:0] idx_o
);
    localparam logic [WFID_W:0] NWF = (WFID_W+1)'(NUM_WF);
    localparam logic [WFID_W:0] ONE = (WFID_W+1)'(1);
    logic [WFID_W:0]     start, off, sum, idx_w;
    logic [2*NUM_WF-1:0] dbl;
    logic [NUM_WF-1:0]   rot;
    always_comb begin
        start = {1'b0, ptr_i} + ONE;
        start = (start >= NWF) ? '0 : start;
        dbl = {req_i, req_i};
        // bit j of rot is slot (start + j) mod NUM_WF
        rot = NUM_WF'(dbl >> start);
        off = '0;
        for (int i = NUM_WF - 1; i >= 0; i--)
            if (rot[i]) off = (WFID_W+1)'(i);
        sum = start + off;
        idx_w = (sum >= NWF) ? sum - NWF : sum;
        idx_o = idx_w[WFID_W-1:0];
        found_o = |req_i;
    end
endmodule

// File: rtl/wf_issue_rr_arbiter.sv
// wf_issue_rr_arbiter: round-robin wavefront issue arbiter with valid/ack grant handshake
//   clk, rst_n     clock, async active-low reset
//   req_i          per-slot ready
//   flush_i        clears pending grant and pointer
//   grant_valid_o  grant pending
//   grant_wfid_o   granted wavefront ID
//   grant_ack_i    issue stage accepts grant
//   ack_err_o      sticky: ack seen with no grant pending
module wf_issue_rr_arbiter
    import wf_issue_rr_arbiter_pkg::*;
#(
    parameter int NUM_WF    = NUM_WF_DEFAULT,
    parameter int WFID_W    = WFID_W_DEFAULT,
    parameter int PTR_RESET = WF_PTR_RESET
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_WF-1:0] req_i,
    input  logic              flush_i,
    output logic              grant_valid_o,
    output logic [WFID_W-1:0] grant_wfid_o,
    input  logic              grant_ack_i,
    output logic              ack_err_o
);
    localparam logic [WFID_W-1:0] PTR_RST = WFID_W'(PTR_RESET);
    arb_state_e        state_q;
    logic [WFID_W-1:0] ptr_q, wfid_q;
    logic              ack_err_q;
    logic [NUM_WF-1:0] pick_req;
    logic [WFID_W-1:0] pick_ptr, pick_idx;
    logic              pick_found;
    // While granting, search past the current grant with it masked so an ack
    // never re-grants the same slot back to back.
    always_comb begin
        pick_req = (state_q == ARB_GRANT) ? req_i & ~(NUM_WF'(1) << wfid_q) : req_i;
        pick_ptr = (state_q == ARB_GRANT) ? wfid_q : ptr_q;
    end
    wf_rr_pick #(.NUM_WF(NUM_WF), .WFID_W(WFID_W)) u_pick (
        .req_i   (pick_req),
        .ptr_i   (pick_ptr),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            ptr_q     <= PTR_RST;
            wfid_q    <= '0;
            ack_err_q <= 1'b0;
        end else begin
            if (grant_ack_i && state_q == ARB_IDLE) ack_err_q <= 1'b1;
            if (state_q == ARB_IDLE) begin
                if (flush_i) ptr_q <= PTR_RST;
                else if (pick_found) begin
                    state_q <= ARB_GRANT;
                    wfid_q  <= pick_idx;
                end
            end else if (flush_i) begin
                state_q <= ARB_IDLE;
                ptr_q   <= PTR_RST;
            end else if (grant_ack_i) begin
                ptr_q <= wfid_q;
                if (pick_found) wfid_q <= pick_idx;
                else state_q <= ARB_IDLE;
            end else if (!req_i[wfid_q]) state_q <= ARB_IDLE;
        end
    end
    assign grant_valid_o = (state_q == ARB_GRANT);
    assign grant_wfid_o  = wfid_q;
    assign ack_err_o     = ack_err_q;
endmodule

// File: tb/tb_wf_issue_rr_arbiter.sv
// tb_wf_issue_rr_arbiter: directed vector bench for the round-robin issue arbiter
module tb_wf_issue_rr_arbiter;
    logic        clk, rst_n, flush, ack, valid, err;
    logic [39:0] req;
    logic [5:0]  wfid;
    int checks = 0, errors = 0;

    typedef struct {
        logic [39:0] req;
        logic        fl;
        logic        ack;
        logic        v;
        logic [5:0]  id;
        logic        err;
    } vec_t;
    vec_t tbl[$];

    wf_issue_rr_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req),
        .flush_i       (flush),
        .grant_valid_o (valid),
        .grant_wfid_o  (wfid),
        .grant_ack_i   (ack),
        .ack_err_o     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [39:0] b(int i);
        logic [39:0] one = 40'd1;
        return one << i;
    endfunction

    task automatic chk(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic step(logic [39:0] r, logic f, logic a);
        req = r;
        flush = f;
        ack = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0;
        flush = 1'b0;
        ack = 1'b0;
        #12;
        chk("reset valid", int'(valid), 0);
        chk("reset wfid", int'(wfid), 0);
        chk("reset err", int'(err), 0);
        rst_n = 1'b1;

        //            req                  fl    ack   v     id     err
        tbl.push_back('{40'd0,              1'b0, 1'b0, 1'b0, 6'd0,  1'b0});
        tbl.push_back('{b(5)|b(2),          1'b0, 1'b0, 1'b1, 6'd2,  1'b0});
        tbl.push_back('{b(5)|b(2),          1'b0, 1'b1, 1'b1, 6'd5,  1'b0});
        tbl.push_back('{b(5)|b(2),          1'b0, 1'b0, 1'b1, 6'd5,  1'b0});
        tbl.push_back('{b(38),              1'b0, 1'b1, 1'b1, 6'd38, 1'b0});
        tbl.push_back('{b(39)|b(0)|b(38),   1'b0, 1'b1, 1'b1, 6'd39, 1'b0});
        tbl.push_back('{b(39)|b(0)|b(38),   1'b0, 1'b1, 1'b1, 6'd0,  1'b0});
        tbl.push_back('{b(39)|b(0)|b(38),   1'b0, 1'b1, 1'b1, 6'd38, 1'b0});
        tbl.push_back('{40'd0,              1'b0, 1'b1, 1'b0, 6'd0,  1'b0});
        tbl.push_back('{b(7)|b(9),          1'b0, 1'b0, 1'b1, 6'd7,  1'b0});
        tbl.push_back('{b(7)|b(9),          1'b0, 1'b0, 1'b1, 6'd7,  1'b0});
        tbl.push_back('{b(7)|b(9),          1'b0, 1'b0, 1'b1, 6'd7,  1'b0});
        tbl.push_back('{b(7)|b(9),          1'b0, 1'b0, 1'b1, 6'd7,  1'b0});
        tbl.push_back('{b(7)|b(9),          1'b0, 1'b0, 1'b1, 6'd7,  1'b0});
        tbl.push_back('{b(9),               1'b0, 1'b0, 1'b0, 6'd0,  1'b0});
        tbl.push_back('{b(9),               1'b0, 1'b0, 1'b1, 6'd9,  1'b0});
        tbl.push_back('{b(12),              1'b0, 1'b1, 1'b1, 6'd12, 1'b0});
        tbl.push_back('{b(12),              1'b0, 1'b1, 1'b0, 6'd0,  1'b0});
        tbl.push_back('{b(12),              1'b0, 1'b0, 1'b1, 6'd12, 1'b0});
        tbl.push_back('{b(12),              1'b0, 1'b1, 1'b0, 6'd0,  1'b0});
        tbl.push_back('{b(12),              1'b0, 1'b0, 1'b1, 6'd12, 1'b0});
        tbl.push_back('{b(20)|b(3),         1'b0, 1'b1, 1'b1, 6'd20, 1'b0});
        tbl.push_back('{b(20)|b(3),         1'b1, 1'b1, 1'b0, 6'd0,  1'b0});
        tbl.push_back('{b(20)|b(3),         1'b0, 1'b0, 1'b1, 6'd3,  1'b0});
        tbl.push_back('{b(20)|b(3),         1'b0, 1'b1, 1'b1, 6'd20, 1'b0});
        tbl.push_back('{40'd0,              1'b0, 1'b1, 1'b0, 6'd0,  1'b0});
        tbl.push_back('{b(5),               1'b1, 1'b0, 1'b0, 6'd0,  1'b0});
        tbl.push_back('{b(5)|b(39),         1'b0, 1'b0, 1'b1, 6'd5,  1'b0});
        tbl.push_back('{b(5)|b(39),         1'b0, 1'b1, 1'b1, 6'd39, 1'b0});
        tbl.push_back('{40'd0,              1'b0, 1'b1, 1'b0, 6'd0,  1'b0});
        tbl.push_back('{40'd0,              1'b0, 1'b1, 1'b0, 6'd0,  1'b1});
        tbl.push_back('{40'd0,              1'b0, 1'b0, 1'b0, 6'd0,  1'b1});

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].req, tbl[i].fl, tbl[i].ack);
            chk($sformatf("vec%0d valid", i), int'(valid), int'(tbl[i].v));
            if (tbl[i].v) chk($sformatf("vec%0d wfid", i), int'(wfid), int'(tbl[i].id));
            chk($sformatf("vec%0d err", i), int'(err), int'(tbl[i].err));
        end

        // Full fairness: pointer is at 39 after the last grant of slot 39 was acked.
        step({40{1'b1}}, 1'b0, 1'b0);
        chk("fair first valid", int'(valid), 1);
        chk("fair first wfid", int'(wfid), 0);
        for (int i = 1; i < 80; i++) begin
            step({40{1'b1}}, 1'b0, 1'b1);
            chk($sformatf("fair%0d valid", i), int'(valid), 1);
            chk($sformatf("fair%0d wfid", i), int'(wfid), i % 40);
        end
        step(40'd0, 1'b0, 1'b1);
        chk("fair end valid", int'(valid), 0);

        // Asynchronous reset while a grant is pending.
        step(b(5), 1'b0, 1'b0);
        chk("pre-reset valid", int'(valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset valid", int'(valid), 0);
        chk("async reset wfid", int'(wfid), 0);
        chk("async reset err", int'(err), 0);
        #2 rst_n = 1'b1;
        step(40'd0, 1'b0, 1'b0);
        step(b(5)|b(2), 1'b0, 1'b0);
        chk("post-reset valid", int'(valid), 1);
        chk("post-reset wfid", int'(wfid), 2);
        step(b(5)|b(2), 1'b0, 1'b1);
        chk("post-reset b2b valid", int'(valid), 1);
        chk("post-reset b2b wfid", int'(wfid), 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
